// File: rtl/result_display.sv
// Captures a signed adder result, converts its magnitude to BCD with a
// sequential double-dabble, and drives a 4-digit multiplexed 7-segment display.
module result_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] sum,
    input  logic       OF_S,
    input  logic       load,
    output logic       busy,
    output logic [3:0] digit_sel,
    output logic [6:0] segments
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_O     = 7'b1000000;

    typedef enum logic [1:0] {IDLE, CONV, SHOW} state_t;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = SEG_BLANK;
        endcase
    endfunction

    state_t          r_state, w_state;
    logic            r_of, w_of, r_sign, w_sign;
    logic [5:0]      r_bin, w_bin;
    logic [3:0]      r_tens, w_tens, r_ones, w_ones;
    logic [2:0]      r_iter, w_iter;
    logic [6:0]      r_disp [4];
    logic [6:0]      w_disp [4];
    logic [CW-1:0]   r_scan_cnt, w_scan_cnt;
    logic [1:0]      r_idx, w_idx;
    logic [3:0]      r_digit_sel;
    logic [6:0]      r_segments;

    logic [5:0]      w_mag;
    logic [3:0]      w_tens_c, w_ones_c, w_sh_tens, w_sh_ones;

    assign w_mag     = sum[5] ? (~sum + 6'd1) : sum;
    assign w_tens_c  = (r_tens >= 4'd5) ? r_tens + 4'd3 : r_tens;
    assign w_ones_c  = (r_ones >= 4'd5) ? r_ones + 4'd3 : r_ones;
    assign w_sh_tens = 4'({w_tens_c, w_ones_c[3]});
    assign w_sh_ones = {w_ones_c[2:0], r_bin[5]};

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        w_state    = r_state;
        w_of       = r_of;
        w_sign     = r_sign;
        w_bin      = r_bin;
        w_tens     = r_tens;
        w_ones     = r_ones;
        w_iter     = r_iter;
        w_disp     = r_disp;
        w_scan_cnt = r_scan_cnt + CW'(1);
        w_idx      = r_idx;

        case (r_state)
            CONV: begin
                w_bin  = r_bin << 1;
                w_tens = w_sh_tens;
                w_ones = w_sh_ones;
                w_iter = r_iter + 3'd1;
                if (r_iter == 3'd5) begin
                    w_state   = SHOW;
                    w_disp[0] = seg7(w_sh_ones);
                    w_disp[1] = (w_sh_tens == 4'd0) ? SEG_BLANK : seg7(w_sh_tens);
                    w_disp[2] = r_sign ? SEG_MINUS : SEG_BLANK;
                    w_disp[3] = r_of ? SEG_O : SEG_BLANK;
                end
            end
            default: begin
                if (load) begin
                    w_state = CONV;
                    w_of    = OF_S;
                    w_sign  = sum[5];
                    w_bin   = w_mag;
                    w_tens  = 4'd0;
                    w_ones  = 4'd0;
                    w_iter  = 3'd0;
                end
            end
        endcase

        // Scan runs independently of the conversion FSM.
        if (r_scan_cnt == CW'(SCAN_DIV - 1)) begin
            w_scan_cnt = '0;
            w_idx      = r_idx + 2'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_of        <= 1'b0;
            r_sign      <= 1'b0;
            r_bin       <= '0;
            r_tens      <= '0;
            r_ones      <= '0;
            r_iter      <= '0;
            r_scan_cnt  <= '0;
            r_idx       <= '0;
            r_digit_sel <= 4'b1110;
            r_segments  <= SEG_BLANK;
            // NOTE: the display register file is reset so it powers up blank.
            for (int i = 0; i < 4; i++) r_disp[i] <= SEG_BLANK;
        end else begin
            r_state     <= w_state;
            r_of        <= w_of;
            r_sign      <= w_sign;
            r_bin       <= w_bin;
            r_tens      <= w_tens;
            r_ones      <= w_ones;
            r_iter      <= w_iter;
            r_scan_cnt  <= w_scan_cnt;
            r_idx       <= w_idx;
            r_disp      <= w_disp;
            // Both outputs are registered from next-state values so they stay aligned.
            r_digit_sel <= ~(4'b0001 << w_idx);
            r_segments  <= w_disp[w_idx];
        end
    end

    assign busy      = (r_state == CONV);
    assign digit_sel = r_digit_sel;
    assign segments  = r_segments;

endmodule

// File: doc/result_display.md
RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, clock cycles each display digit is held before the scan advances; legal range 2 or more.
REQ-002 SHALL have port clk, input, 1 bit, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port sum, input, 6 bits, two's-complement result from the adder stage (-32..31).
REQ-005 SHALL have port OF_S, input, 1 bit, overflow flag from the adder stage.
REQ-006 SHALL have port load, input, 1 bit, capture strobe for sum and OF_S.
REQ-007 SHALL have port busy, output, 1 bit, high while a conversion is in progress.
REQ-008 SHALL have port digit_sel, output, 4 bits, active-low one-hot digit enable; bit 0 is the rightmost digit.
REQ-009 SHALL have port segments, output, 7 bits, active-low pattern ordered gfedcba, for the currently selected digit.

Function
REQ-010 SHALL implement the states IDLE, CONV and SHOW.
REQ-011 SHALL move to CONV on an edge where load=1 in IDLE or SHOW, capturing OF_S, the sign bit sum[5] and the 6-bit unsigned magnitude |sum| (-32 gives 32).
REQ-012 SHALL ignore load while in CONV: the captured values do not change and conversion is not restarted.
REQ-013 SHALL convert the magnitude to tens/ones BCD with double-dabble, one shift iteration per clock; "add 3 if ≥5" correction applies before each shift.
REQ-014 SHALL take exactly 6 iterations, on edges k+1..k+6 after the capture edge k.
REQ-015 SHALL, on edge k+6, latch the display registers and enter SHOW.
REQ-016 SHALL drive busy=1 for exactly the 6 cycles following the capture edge, and 0 otherwise.
REQ-017 SHALL keep the previous display contents unchanged during CONV.
REQ-018 SHALL drive digit 0 with the ones BCD digit.
REQ-019 SHALL drive digit 1 with the tens BCD digit, blank when tens=0.
REQ-020 SHALL drive digit 2 with '-' when the captured sign=1, blank otherwise.
REQ-021 SHALL drive digit 3 with 'O' when the captured OF_S=1, blank otherwise.
REQ-022 SHALL use these segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, '-'=0111111, 'O'=1000000, blank=1111111.
REQ-023 SHALL run a scan counter 0..SCAN_DIV-1 in every state; on wrap, the digit index advances 0→1→2→3→0.
REQ-024 SHALL drive digit_sel = ~(1<<index).
REQ-025 SHALL update segments in the same cycle as digit_sel; both are registered outputs.
REQ-026 SHALL not disturb the scan counter or digit index on a load or on a state change.
REQ-027 SHALL return to SHOW after a new conversion; SHOW is never left except by load or reset.

Reset
REQ-028 SHALL, on reset=1 at an edge, enter IDLE from any state, including mid-CONV.
REQ-029 SHALL, on reset, clear the scan counter, digit index and BCD registers, and set all display registers to blank.
REQ-030 SHALL, on reset, set busy=0, digit_sel=1110 and segments=1111111.
REQ-031 SHALL give reset priority over a simultaneous load.

Verification
REQ-032 SHALL cover: reset held 2 cycles → busy=0, digit_sel=1110, segments=1111111 on every scanned digit.
REQ-033 SHALL cover: sum=6'd23, OF_S=0, 1-cycle load → busy=1 for 6 cycles; then digit0=0110000, digit1=0100100, digit2=1111111, digit3=1111111.
REQ-034 SHALL cover: sum=6'b100000, OF_S=1, load → digit0=0100100, digit1=0110000, digit2=0111111, digit3=1000000.
REQ-035 SHALL cover: sum=6'd7 then, in SHOW, sum=6'b111101 (-3) with load → first digit1 blank and digit0=1111000; after 6 busy cycles digit0=0110000, digit2=0111111.
REQ-036 SHALL cover: load at cycle 3 of CONV with a different sum → ignored, original result shown; reset asserted mid-CONV → busy=0, all digits blank next cycle.
REQ-037 SHALL cover: SCAN_DIV=4 → digit_sel sequence 1110, 1101, 1011, 0111, 1110, each held exactly 4 cycles, unaffected by load.
